// File: rtl/insn_fetch_unit_if.sv
// Instruction memory read port between the fetch unit and instruction memory.
//   imem_req   : read request, held until imem_ack
//   imem_addr  : read address, stable while a request is waiting for its ack
//   imem_ack   : read data valid this cycle (may coincide with the request rising)
//   imem_rdata : instruction word, sampled when imem_ack=1
// master = fetch unit, slave = memory.
interface insn_fetch_unit_if #(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned INSTR_WIDTH = 32
);
  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_ack;
  logic [INSTR_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/insn_fetch_unit.sv
// Instruction fetch stage feeding the instruction converter.
// Generates sequential fetch addresses, runs a single-outstanding req/ack
// handshake with instruction memory, buffers up to two {pc, word} pairs and
// presents the head pair. The presented pair is frozen while stall_in=1.
// A redirect flushes buffered and in-flight fetches and restarts at
// redirect_pc (word-aligned).
//   clk, rst        : clock, asynchronous active-high reset
//   stall_in        : hold the presented instruction
//   redirect_valid  : one-cycle flush/restart pulse
//   redirect_pc     : restart address (two LSBs ignored)
//   imem            : instruction memory port (master side)
//   PC, instr       : presented instruction and its address
//   instr_valid     : PC/instr carry a real instruction
module insn_fetch_unit #(
  parameter int unsigned             PC_WIDTH    = 32,
  parameter int unsigned             INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]     RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0]  NOP_WORD    = 32'h6000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_in,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  insn_fetch_unit_if.master      imem,
  output logic [PC_WIDTH-1:0]    PC,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DROP
  } state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0]    drop_addr_q;
  logic [1:0]             count_q, count_d;
  logic [PC_WIDTH-1:0]    buf_pc   [2];
  logic [INSTR_WIDTH-1:0] buf_word [2];

  logic                   valid;
  logic                   pop;
  logic                   push;
  logic                   enter_drop;
  logic [PC_WIDTH-1:0]    redirect_tgt;

  always_comb begin
    redirect_tgt = redirect_pc & ~PC_WIDTH'(3);
    valid        = (count_q != 2'd0);
    pop          = valid & ~stall_in & ~redirect_valid;
    push         = (state_q == S_REQ) & imem.imem_ack & ~redirect_valid;
    enter_drop   = (state_q == S_REQ) & redirect_valid & ~imem.imem_ack;
    if (redirect_valid) begin
      count_d = 2'd0;
    end else begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    unique case (state_q)
      S_IDLE: begin
        if (redirect_valid || (count_d < 2'd2)) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (redirect_valid) begin
          // An ack arriving with the redirect completes the old request,
          // so the new address can be issued immediately.
          state_d = imem.imem_ack ? S_REQ : S_DROP;
        end else if (imem.imem_ack) begin
          fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);
          state_d    = (count_d < 2'd2) ? S_REQ : S_IDLE;
        end
      end
      S_DROP: begin
        if (!redirect_valid && imem.imem_ack) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect_valid) begin
      fetch_pc_d = redirect_tgt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= RESET_PC;
      count_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      // Memory still sees the abandoned address until its ack arrives,
      // while fetch_pc already holds the redirect target.
      if (enter_drop) begin
        drop_addr_q <= fetch_pc_q;
      end
    end
  end

  // Two-entry buffer, entry 0 is always the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_pc[0]   <= '0;
      buf_pc[1]   <= '0;
      buf_word[0] <= '0;
      buf_word[1] <= '0;
    end else if (push) begin
      if (pop) begin
        if (count_q == 2'd2) begin
          buf_pc[0]   <= buf_pc[1];
          buf_word[0] <= buf_word[1];
          buf_pc[1]   <= fetch_pc_q;
          buf_word[1] <= imem.imem_rdata;
        end else begin
          buf_pc[0]   <= fetch_pc_q;
          buf_word[0] <= imem.imem_rdata;
        end
      end else if (count_q == 2'd0) begin
        buf_pc[0]   <= fetch_pc_q;
        buf_word[0] <= imem.imem_rdata;
      end else begin
        buf_pc[1]   <= fetch_pc_q;
        buf_word[1] <= imem.imem_rdata;
      end
    end else if (pop) begin
      buf_pc[0]   <= buf_pc[1];
      buf_word[0] <= buf_word[1];
    end
  end

  always_comb begin
    imem.imem_req  = (state_q != S_IDLE);
    imem.imem_addr = (state_q == S_DROP) ? drop_addr_q : fetch_pc_q;
    instr_valid    = valid;
    PC             = valid ? buf_pc[0]   : fetch_pc_q;
    instr          = valid ? buf_word[0] : NOP_WORD;
  end

endmodule

// File: tb/tb_insn_fetch_unit.sv
module tb_insn_fetch_unit;
  localparam logic [31:0] NOP  = 32'h6000_0000;
  localparam logic [31:0] MARK = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] PC;
  logic [31:0] instr;
  logic        instr_valid;

  insn_fetch_unit_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) imem ();

  insn_fetch_unit #(
    .PC_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h0), .NOP_WORD(32'h6000_0000)
  ) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem(imem), .PC(PC), .instr(instr),
    .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Memory model state
  int unsigned cnt;
  int unsigned lat;
  logic        mode_rnd;
  logic        ack_force;
  logic        last_req, last_ack;

  // Scoreboard state: expected program-order stream plus previous-cycle view
  logic [31:0] exp_pc;
  int          pops;
  logic        p_valid, p_stall, p_redir, p_req, p_ack;
  logic [31:0] p_pc, p_instr, p_addr;

  typedef struct {
    logic        s;
    logic        r;
    logic [31:0] rp;
    logic        v;
    logic [31:0] pc;
    logic        req;
    logic [31:0] addr;
  } vec_t;
  vec_t tbl [21];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic setv(input int i, input logic s, input logic r, input logic [31:0] rp,
                      input logic v, input logic [31:0] pc, input logic req,
                      input logic [31:0] addr);
    tbl[i].s = s; tbl[i].r = r; tbl[i].rp = rp;
    tbl[i].v = v; tbl[i].pc = pc; tbl[i].req = req; tbl[i].addr = addr;
  endtask

  task automatic clear_model();
    exp_pc = 32'h0;
    p_valid = 0; p_stall = 0; p_redir = 0; p_req = 0; p_ack = 0;
    p_pc = '0; p_instr = '0; p_addr = '0;
    cnt = 0; last_req = 0; last_ack = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall_in = 0; redirect_valid = 0; redirect_pc = '0;
    imem.imem_ack = 0; imem.imem_rdata = '0; ack_force = 0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Memory answers with address|MARK so every word identifies its source.
  task automatic mem_drive();
    logic a;
    a = 1'b0;
    if (imem.imem_req) begin
      if (mode_rnd) a = (cnt >= 3) || ($urandom_range(0, 2) == 0);
      else          a = (cnt >= lat);
    end
    imem.imem_ack   = a | ack_force;
    imem.imem_rdata = imem.imem_addr | MARK;
    last_req = imem.imem_req;
    last_ack = imem.imem_ack;
  endtask

  task automatic monitor();
    logic pop;
    if (instr_valid) chk("data", instr, PC | MARK);
    else             chk("nop", instr, NOP);
    if (p_redir) chk("flush", {31'b0, instr_valid}, 32'h0);
    if (p_valid && p_stall && !p_redir) begin
      chk("hold_valid", {31'b0, instr_valid}, 32'h1);
      chk("hold_pc", PC, p_pc);
      chk("hold_instr", instr, p_instr);
    end
    if (p_req && !p_ack) begin
      chk("req_held", {31'b0, imem.imem_req}, 32'h1);
      chk("addr_held", imem.imem_addr, p_addr);
    end
    pop = instr_valid && !stall_in && !redirect_valid;
    if (pop) begin
      chk("order", PC, exp_pc);
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (redirect_valid) exp_pc = redirect_pc & ~32'd3;
    p_valid = instr_valid; p_stall = stall_in; p_redir = redirect_valid;
    p_req = imem.imem_req; p_ack = imem.imem_ack;
    p_pc = PC; p_instr = instr; p_addr = imem.imem_addr;
  endtask

  task automatic step_a(input logic s, input logic r, input logic [31:0] rp);
    stall_in = s; redirect_valid = r; redirect_pc = rp;
    mem_drive();
    @(negedge clk);
    monitor();
  endtask

  task automatic step_b();
    @(posedge clk);
    #1;
    if (last_ack)      cnt = 0;
    else if (last_req) cnt++;
    else               cnt = 0;
  endtask

  initial begin
    int unsigned gaps;
    logic        seen, found, r;
    int          p0;
    logic [31:0] v;

    pops = 0; mode_rnd = 0; lat = 0;

    // Zero-wait, cycle-exact table starting from reset release
    setv( 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
    setv( 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0);
    setv( 2, 0, 0, 32'h0,        1, 32'h0,        1, 32'h4);
    setv( 3, 0, 0, 32'h0,        1, 32'h4,        1, 32'h8);
    setv( 4, 1, 0, 32'h0,        1, 32'h8,        1, 32'hC);
    setv( 5, 1, 0, 32'h0,        1, 32'h8,        0, 32'h10);
    setv( 6, 1, 0, 32'h0,        1, 32'h8,        0, 32'h10);
    setv( 7, 1, 0, 32'h0,        1, 32'h8,        0, 32'h10);
    setv( 8, 1, 0, 32'h0,        1, 32'h8,        0, 32'h10);
    setv( 9, 0, 0, 32'h0,        1, 32'h8,        0, 32'h10);
    setv(10, 0, 0, 32'h0,        1, 32'hC,        1, 32'h10);
    setv(11, 0, 1, 32'h200,      1, 32'h10,       1, 32'h14);
    setv(12, 0, 0, 32'h0,        0, 32'h200,      1, 32'h200);
    setv(13, 0, 0, 32'h0,        1, 32'h200,      1, 32'h204);
    setv(14, 0, 1, 32'hFFFFFFFF, 1, 32'h204,      1, 32'h208);
    setv(15, 0, 0, 32'h0,        0, 32'hFFFFFFFC, 1, 32'hFFFFFFFC);
    setv(16, 0, 0, 32'h0,        1, 32'hFFFFFFFC, 1, 32'h0);
    setv(17, 1, 0, 32'h0,        1, 32'h0,        1, 32'h4);
    setv(18, 1, 1, 32'h300,      1, 32'h0,        0, 32'h8);
    setv(19, 0, 0, 32'h0,        0, 32'h300,      1, 32'h300);
    setv(20, 0, 0, 32'h0,        1, 32'h300,      1, 32'h304);

    do_reset();
    for (int i = 0; i < 21; i++) begin
      step_a(tbl[i].s, tbl[i].r, tbl[i].rp);
      chk($sformatf("tbl%0d_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].v});
      chk($sformatf("tbl%0d_pc", i), PC, tbl[i].pc);
      chk($sformatf("tbl%0d_instr", i), instr, tbl[i].v ? (tbl[i].pc | MARK) : NOP);
      chk($sformatf("tbl%0d_req", i), {31'b0, imem.imem_req}, {31'b0, tbl[i].req});
      chk($sformatf("tbl%0d_addr", i), imem.imem_addr, tbl[i].addr);
      step_b();
    end

    // Slow memory; redirect to 0x200 while the fetch of 0x10 is waiting
    do_reset();
    lat = 3; gaps = 0; seen = 0; found = 0;
    for (int i = 0; i < 60; i++) begin
      r = !found && imem.imem_req && (imem.imem_addr == 32'h10) && (cnt < lat);
      if (r) found = 1;
      step_a(0, r, 32'h200);
      if (seen && !instr_valid) gaps++;
      if (instr_valid) seen = 1;
      step_b();
    end
    chk("redir_found", {31'b0, found}, 32'h1);
    chk("valid_gaps", {31'b0, (gaps != 0)}, 32'h1);
    chk("post_redir_progress", {31'b0, (exp_pc >= 32'h208 && exp_pc < 32'h300)}, 32'h1);

    // Reset in the middle of a request, then a stray ack while IDLE
    do_reset();
    lat = 3;
    step_a(0, 0, 0); step_b();
    step_a(0, 0, 0); step_b();
    rst = 1'b1;
    #1;
    chk("rst_req", {31'b0, imem.imem_req}, 32'h0);
    chk("rst_addr", imem.imem_addr, 32'h0);
    chk("rst_pc", PC, 32'h0);
    chk("rst_instr", instr, NOP);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    imem.imem_ack = 0;
    clear_model();
    @(posedge clk);
    #1 rst = 1'b0;
    ack_force = 1;
    step_a(0, 0, 0);
    step_b();
    ack_force = 0;
    step_a(0, 0, 0);
    chk("stray_ack_valid", {31'b0, instr_valid}, 32'h0);
    chk("stray_ack_req", {31'b0, imem.imem_req}, 32'h1);
    chk("stray_ack_addr", imem.imem_addr, 32'h0);
    step_b();

    // Randomized traffic against the scoreboard
    do_reset();
    mode_rnd = 1;
    p0 = pops;
    for (int i = 0; i < 3000; i++) begin
      v = $urandom;
      if ($urandom_range(0, 1) == 1) v = 32'hFFFF_FFF0 | (v & 32'hF);
      step_a(($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0), v);
      step_b();
    end
    chk("rnd_progress", {31'b0, ((pops - p0) > 300)}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
